// File: rtl/temp_scan_sequencer.sv
// Four-channel temperature scan front end: settles the analog mux, clocks one
// 12-bit serial ADC frame per channel and publishes the clamped 10-bit result.
module temp_scan_sequencer #(
  parameter int CLK_DIV       = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int TEMP_MAX      = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [1:0] chan,
  output logic [9:0] temp,
  output logic [3:0] select,
  output logic       sample_valid,
  output logic       over_range
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CONV    = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam int            TMAX_C      = (TEMP_MAX > 1023) ? 1023 :
                                          ((TEMP_MAX < 0) ? 0 : TEMP_MAX);
  localparam logic [9:0]    TMAX        = 10'(TMAX_C);

  logic [1:0]    state;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] div_cnt;
  logic [4:0]    edge_cnt;
  logic [9:0]    shift;
  logic          pub_done;

  function automatic logic [9:0] clamp_temp(input logic [9:0] raw);
    return (raw > TMAX) ? TMAX : raw;
  endfunction

  function automatic logic is_over(input logic [9:0] raw);
    return raw > TMAX;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      shift        <= '0;
      pub_done     <= 1'b0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      chan         <= 2'd0;
      temp         <= '0;
      select       <= 4'hF;
      sample_valid <= 1'b0;
      over_range   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state    <= S_CONV;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        // 24 sclk toggles per frame; data is captured on the toggle that raises sclk
        S_CONV: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            adc_sclk <= ~adc_sclk;
            if (!adc_sclk) shift <= {shift[8:0], adc_miso};
            if (edge_cnt == 5'd23) begin
              adc_cs_n <= 1'b1;
              adc_sclk <= 1'b0;
              pub_done <= 1'b0;
              state    <= S_PUBLISH;
            end else begin
              edge_cnt <= edge_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // First cycle drives the strobe, second clears it and advances the mux
        S_PUBLISH: begin
          if (!pub_done) begin
            pub_done     <= 1'b1;
            temp         <= clamp_temp(shift);
            over_range   <= is_over(shift);
            select       <= ~(4'b0001 << chan);
            sample_valid <= 1'b1;
          end else begin
            select       <= 4'hF;
            sample_valid <= 1'b0;
            over_range   <= 1'b0;
            chan         <= chan + 2'd1;
            settle_cnt   <= '0;
            state        <= en ? S_SETTLE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_scan_sequencer.sv
// Bench for temp_scan_sequencer: serial ADC model, vector table, directed
// corner sequences, randomized scoreboard run and a CLK_DIV=2 bus check.
module tb_temp_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, adc_miso, adc_cs_n, adc_sclk;
  logic [1:0] chan;
  logic [9:0] temp;
  logic [3:0] select;
  logic       sample_valid, over_range;

  logic       rst2, en2, adc_miso2, adc_cs_n2, adc_sclk2;
  logic [1:0] chan2;
  logic [9:0] temp2;
  logic [3:0] select2;
  logic       sample_valid2, over_range2;

  always #5 clk = ~clk;

  temp_scan_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .adc_miso(adc_miso),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .chan(chan), .temp(temp),
    .select(select), .sample_valid(sample_valid), .over_range(over_range)
  );

  temp_scan_sequencer #(.CLK_DIV(2), .SETTLE_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .adc_miso(adc_miso2),
    .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2), .chan(chan2), .temp(temp2),
    .select(select2), .sample_valid(sample_valid2), .over_range(over_range2)
  );

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // ADC model: frame = {2 null bits, value of current mux channel}, MSB first,
  // next bit presented after each observed sclk rise.
  logic [9:0]  adc_val [4];
  logic [11:0] frame = '0;
  int          rises_m = 0;
  logic        prev_sclk_m = 1'b0;

  always @(negedge clk) begin
    if (adc_cs_n) begin
      frame   = {2'($urandom_range(0, 3)), adc_val[chan]};
      rises_m = 0;
    end else if (adc_sclk && !prev_sclk_m) begin
      rises_m++;
    end
    prev_sclk_m = adc_sclk;
    adc_miso = (!adc_cs_n && rises_m < 12) ? frame[11 - rises_m] : 1'b0;
  end

  // Continuous output invariants, skipped for the cycle a reset was applied
  logic       rst_q = 1'b1;
  int         inv_err = 0;
  logic [3:0] prev_sel = 4'hF;
  logic [9:0] prev_temp = '0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (!rst_q) begin
      if (select != 4'hF && !(select inside {4'hE, 4'hD, 4'hB, 4'h7})) inv_err++;
      if (select != 4'hF && prev_sel != 4'hF) inv_err++;
      if (adc_cs_n && adc_sclk) inv_err++;
      if (temp > 10'd999) inv_err++;
      if (!sample_valid && temp != prev_temp) inv_err++;
    end
    prev_sel  = select;
    prev_temp = temp;
  end

  typedef struct {
    logic [9:0] raw;
    logic [9:0] exp_temp;
    logic       exp_over;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pub(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sample_valid && cyc < limit);
    check("publish_seen", int'(sample_valid), 1);
  endtask

  function automatic logic [3:0] sel_of(input int ch);
    return ~(4'b0001 << ch);
  endfunction

  initial begin
    int cyc, t3, rises, lows, npub, cycles, exp_chan, frames, bus_err;
    logic prev, pcs, psclk;
    logic [9:0] raw, exp_t;
    logic [9:0] q[$];

    rst = 1'b1; en = 1'b0; rst2 = 1'b1; en2 = 1'b0; adc_miso2 = 1'b0;
    for (int i = 0; i < 4; i++) adc_val[i] = 10'd0;
    vecs[0] = '{10'h15A, 10'd346, 1'b0};
    vecs[1] = '{10'd1023, 10'd999, 1'b1};
    vecs[2] = '{10'd999, 10'd999, 1'b0};
    vecs[3] = '{10'd1000, 10'd999, 1'b1};
    vecs[4] = '{10'd0, 10'd0, 1'b0};
    vecs[5] = '{10'd512, 10'd512, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_cs_n", int'(adc_cs_n), 1);
    check("rst_sclk", int'(adc_sclk), 0);
    check("rst_chan", int'(chan), 0);
    check("rst_temp", int'(temp), 0);
    check("rst_select", int'(select), 15);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_over", int'(over_range), 0);

    // Vector table: ch0 result, clamp and over_range flag
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) adc_val[c] = vecs[i].raw;
      restart();
      wait_pub(300, cyc);
      check("vec_temp", int'(temp), int'(vecs[i].exp_temp));
      check("vec_over", int'(over_range), int'(vecs[i].exp_over));
      check("vec_select", int'(select), 14);
      if (i == 0) begin
        // en sampled on the first edge; publish is 16+96+1 edges after it
        check("first_latency", cyc, 114);
        @(negedge clk);
        check("strobe_cleared", int'(select), 15);
        check("valid_cleared", int'(sample_valid), 0);
        check("temp_held", int'(temp), 346);
      end
    end

    // Rotation through all four channels and wrap back to ch0
    adc_val[0] = 10'd100; adc_val[1] = 10'd200; adc_val[2] = 10'd300; adc_val[3] = 10'd400;
    restart();
    for (int k = 0; k < 4; k++) begin
      wait_pub(300, cyc);
      check("rot_temp", int'(temp), 100 * (k + 1));
      check("rot_select", int'(select), int'(sel_of(k)));
    end
    t3 = cyc_now;
    @(negedge clk);
    check("wrap_chan", int'(chan), 0);
    wait_pub(300, cyc);
    check("wrap_period", cyc_now - t3, 114);
    check("wrap_select", int'(select), 14);
    check("wrap_temp", int'(temp), 100);

    // Reset at the 6th sclk rise of the ch1 frame
    adc_val[0] = 10'd50; adc_val[1] = 10'd60; adc_val[2] = 10'd70; adc_val[3] = 10'd80;
    restart();
    wait_pub(300, cyc);
    rises = 0; prev = adc_sclk; cyc = 0;
    while (rises < 6 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (adc_cs_n) rises = 0;
      else if (adc_sclk && !prev) rises++;
      prev = adc_sclk;
    end
    check("midconv_reached", rises, 6);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", int'(adc_cs_n), 1);
    check("mid_rst_sclk", int'(adc_sclk), 0);
    check("mid_rst_temp", int'(temp), 0);
    check("mid_rst_chan", int'(chan), 0);
    check("mid_rst_select", int'(select), 15);
    rst = 1'b0;
    wait_pub(300, cyc);
    check("no_partial_publish", cyc, 114);
    check("post_rst_select", int'(select), 14);
    check("post_rst_temp", int'(temp), 50);

    // Drop en during the ch2 conversion
    adc_val[0] = 10'd11; adc_val[1] = 10'd22; adc_val[2] = 10'd33; adc_val[3] = 10'd44;
    restart();
    wait_pub(300, cyc);
    wait_pub(300, cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(chan == 2'd2 && !adc_cs_n) && cyc < 300);
    check("ch2_conv_reached", int'(chan == 2'd2 && !adc_cs_n), 1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_pub(300, cyc);
    check("drop_select", int'(select), 11);
    check("drop_temp", int'(temp), 33);
    @(negedge clk);
    check("drop_chan", int'(chan), 3);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!adc_cs_n || sample_valid) lows++;
    end
    check("idle_quiet", lows, 0);
    check("idle_chan", int'(chan), 3);
    en = 1'b1;
    wait_pub(300, cyc);
    check("resume_latency", cyc, 114);
    check("resume_select", int'(select), 7);
    check("resume_temp", int'(temp), 44);

    // Randomized run: frames publish in channel order with clamped values
    for (int c = 0; c < 4; c++) adc_val[c] = 10'($urandom_range(0, 1023));
    restart();
    q.delete();
    exp_chan = 0; npub = 0; cycles = 0; pcs = 1'b1;
    while (npub < 40 && cycles < 30000) begin
      @(negedge clk);
      cycles++;
      if (pcs && !adc_cs_n) q.push_back(frame[9:0]);
      pcs = adc_cs_n;
      if (sample_valid) begin
        if (q.size() == 0) begin
          check("sb_frame_pending", 0, 1);
        end else begin
          raw   = q.pop_front();
          exp_t = (raw > 10'd999) ? 10'd999 : raw;
          check("sb_temp", int'(temp), int'(exp_t));
          check("sb_over", int'(over_range), int'(raw > 10'd999));
          check("sb_select", int'(select), int'(sel_of(exp_chan)));
        end
        exp_chan = (exp_chan + 1) % 4;
        npub++;
        for (int c = 0; c < 4; c++)
          adc_val[c] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                                   : 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 149) == 0) en = ~en;
    end
    check("sb_publish_count", npub, 40);
    en = 1'b0;

    // Bus shape at CLK_DIV=2 over 100 frames
    @(negedge clk);
    rst2 = 1'b0; en2 = 1'b1;
    frames = 0; rises = 0; bus_err = 0; cycles = 0; pcs = 1'b1; psclk = 1'b0;
    while (frames < 100 && cycles < 10000) begin
      @(negedge clk);
      cycles++;
      adc_miso2 = 1'($urandom_range(0, 1));
      if (!adc_cs_n2) begin
        if (adc_sclk2 && !psclk) rises++;
      end else begin
        if (adc_sclk2) bus_err++;
        if (!pcs) begin
          check("frame_rises", rises, 12);
          frames++;
          rises = 0;
        end
      end
      pcs = adc_cs_n2;
      psclk = adc_sclk2;
    end
    check("bus_frames", frames, 100);
    check("bus_sclk_idle", bus_err, 0);
    check("invariants", inv_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_scan_sequencer.md
# temp_scan_sequencer

Upstream front end for the four-channel temperature averaging/display stage. Steps an analog mux through four sensor channels and reads each one from a 12-bit-frame serial ADC. Presents each 10-bit result on `temp` with a one-cycle active-low `select` strobe, which the averaging stage uses to latch the value into its per-channel register. Runs continuously while enabled, so all four channel registers downstream refresh in rotation.

## Interface
- `CLK_DIV`, default 4: clk cycles per `adc_sclk` half-period; legal range ≥2.
- `SETTLE_CYCLES`, default 16: clk cycles the mux settles after a channel change, before a conversion starts; legal range ≥1.
- `TEMP_MAX`, default 999: clamp ceiling on published values, which keeps the downstream display at 3 digits.
- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; level-sensitive.
- `adc_miso`  in  1  ADC serial data, MSB first.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock; idles low.
- `chan`  out  2  analog mux channel, 0–3.
- `temp`  out  10  last published sample; held between publishes.
- `select`  out  4  one-cold write strobe: 1110 = ch0, 1101 = ch1, 1011 = ch2, 0111 = ch3; 1111 = none.
- `sample_valid`  out  1  high for the single publish cycle.
- `over_range`  out  1  high with `sample_valid` when the raw value exceeded `TEMP_MAX`.

## Operation
- FSM states: IDLE, SETTLE, CONV, PUBLISH.
- IDLE:
  - `adc_cs_n`=1, `adc_sclk`=0, `select`=1111.
  - Moves to SETTLE when `en`=1.
- SETTLE:
  - Counts `SETTLE_CYCLES` cycles with `adc_cs_n` high and `chan` stable.
  - Then moves to CONV.
- CONV:
  - `adc_cs_n` is low for the whole state.
  - `adc_sclk` toggles every `CLK_DIV` cycles, giving 12 rising edges.
  - `adc_miso` is sampled on the clk edge where the registered `adc_sclk` goes 0→1.
  - Bits 1–2 are null and discarded; bits 3–12 are data[9:0], MSB first.
  - After the 12th falling edge, `adc_cs_n` returns high and the FSM moves to PUBLISH.
- PUBLISH, exactly 1 cycle:
  - `temp` ← min(raw, `TEMP_MAX`).
  - `over_range` ← (raw > `TEMP_MAX`).
  - `select` ← the pattern for `chan`.
  - `sample_valid`=1.
- Cycle after PUBLISH:
  - `select` returns to 1111 and `sample_valid`, `over_range` return to 0.
  - `chan` ← (`chan`+1) mod 4, wrapping 3→0.
  - Goes to SETTLE if `en`=1, otherwise IDLE.
- `en` deasserted during SETTLE: return to IDLE on the next edge; `chan` is unchanged.
- `en` deasserted during CONV: the frame completes and publishes normally, then the FSM goes to IDLE.
- Width/arithmetic rules:
  - Raw value is 10-bit unsigned.
  - Clamp comparison is unsigned.
  - `temp` never exceeds `TEMP_MAX`.
- Reset, including mid-frame, takes effect on the next edge:
  - State = IDLE.
  - `adc_cs_n`=1, `adc_sclk`=0, `chan`=0, `temp`=0.
  - `select`=1111, `sample_valid`=0, `over_range`=0.
  - Shift register cleared; a partial frame is discarded and never published.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `adc_cs_n` falls on the edge that enters CONV. The first `adc_sclk` rise occurs `CLK_DIV` cycles later.
- Frame length: 24·`CLK_DIV` cycles of `adc_cs_n` low (96 cycles at default).
- Per-channel period: `SETTLE_CYCLES` + 24·`CLK_DIV` + 1 + 1 cycles, which is 114 at default. A full four-channel sweep takes 456 cycles.
- Latency: the last data bit is sampled, then `adc_cs_n` rises `CLK_DIV` cycles later. `sample_valid`, `temp` and `select` update together on the next edge.
- Downstream capture:
  - The downstream stage latches `temp` on the edge after the publish cycle, while `select` shows the pattern.
  - `temp` stays stable at least until the next publish, so there is no setup hazard.
- `select` is never low on two consecutive cycles, and never has more than one bit low.

## Test plan
- Reset, then `en`=1, ADC model returns 0x15A (346) on ch0:
  - `select`=1110 and `temp`=346 for exactly 1 cycle.
  - `sample_valid` is high on the same cycle.
  - First publish occurs 16+96+1 cycles after `en` is sampled high.
- Model returns 100, 200, 300, 400 on ch0–3:
  - Publishes in order with `select` 1110, 1101, 1011, 0111.
  - `chan` wraps 3→0; the next ch0 publish follows 114 cycles after ch3.
- Model returns 1023:
  - `temp`=999 and `over_range`=1 during the publish cycle.
  - Model returning 999 gives `over_range`=0.
- Assert `rst` mid-CONV, at the 6th `adc_sclk` rise:
  - Next edge: `adc_cs_n`=1, `adc_sclk`=0, `temp`=0, `chan`=0.
  - No `sample_valid` pulse follows.
- Drop `en` mid-CONV on ch2:
  - The ch2 value publishes with `select`=1011.
  - The FSM then goes to IDLE with `chan`=3 and `adc_cs_n` stays high.
  - Re-asserting `en` resumes at ch3.
- Bus check, `CLK_DIV`=2, 100 frames: every frame has exactly 12 `adc_sclk` rises while `adc_cs_n`=0, and `adc_sclk` is low whenever `adc_cs_n`=1.
